// File: rtl/gtp_reset_sequencer.sv
// gtp_reset_sequencer
//   Fabric-side bring-up controller for one GTPE2_COMMON PLL0 and the GTPE2_CHANNEL it
//   clocks. Pulses PLL0 reset and waits for lock. Then it pulses the channel TX/RX
//   resets and waits for both reset-done flags before declaring the link ready.
//   A timeout triggers a retry from the PLL reset. Loss of lock in READY triggers a
//   full re-initialisation.
//
// Ports
//   clk            in   single clock for all logic
//   rst_n          in   asynchronous active-low reset
//   start          in   1-cycle request to begin (re)initialisation (synchronous)
//   pll0_lock      in   PLL0LOCK from COMMON (asynchronous, synchronised here)
//   tx_reset_done  in   TXRESETDONE from CHANNEL (asynchronous, synchronised here)
//   rx_reset_done  in   RXRESETDONE from CHANNEL (asynchronous, synchronised here)
//   pll0_reset     out  PLL0RESET to COMMON
//   gt_tx_reset    out  GTTXRESET to CHANNEL
//   gt_rx_reset    out  GTRXRESET to CHANNEL
//   ready          out  link initialised and PLL locked
//   error          out  sticky: retries exhausted
//   retry_count    out  timeouts taken in the current attempt sequence
module gtp_reset_sequencer #(
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter int unsigned PLL_LOCK_TIMEOUT   = 65535,
  parameter int unsigned DONE_TIMEOUT       = 65535,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pll0_lock,
  input  logic       tx_reset_done,
  input  logic       rx_reset_done,
  output logic       pll0_reset,
  output logic       gt_tx_reset,
  output logic       gt_rx_reset,
  output logic       ready,
  output logic       error,
  output logic [1:0] retry_count
);

  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PllLast   = CNT_W'(PLL_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DoneLast  = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [1:0]       MaxRetry  = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StPllRst,
    StPllWait,
    StGtRst,
    StGtWait,
    StReady,
    StFail
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             timeout;

  // Two-stage synchronisers: bit 2 lock, bit 1 tx done, bit 0 rx done.
  logic [2:0] sync1_q, sync2_q;
  logic       lock_s, tx_done_s, rx_done_s;

  logic pll0_reset_q, pll0_reset_d;
  logic gt_reset_q, gt_reset_d;
  logic ready_q, ready_d;
  logic error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {pll0_lock, tx_reset_done, rx_reset_done};
      sync2_q <= sync1_q;
    end
  end

  assign lock_s    = sync2_q[2];
  assign tx_done_s = sync2_q[1];
  assign rx_done_s = sync2_q[0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPllRst;
          retry_d = 2'd0;
        end
      end
      StPllRst: begin
        if (cnt_q == PulseLast) state_d = StPllWait;
      end
      StPllWait: begin
        if (lock_s) begin
          state_d = StGtRst;
        end else if (cnt_q == PllLast) begin
          timeout = 1'b1;
        end
      end
      StGtRst: begin
        if (cnt_q == PulseLast) state_d = StGtWait;
      end
      StGtWait: begin
        if (tx_done_s && rx_done_s) begin
          state_d = StReady;
        end else if (cnt_q == DoneLast) begin
          timeout = 1'b1;
        end
      end
      StReady: begin
        // Done flags are ignored here; only lock loss restarts the sequence.
        if (!lock_s) begin
          state_d = StPllRst;
          retry_d = 2'd0;
        end
      end
      StFail: begin
        if (start) begin
          state_d = StPllRst;
          retry_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A retry always restarts from the PLL reset; the count holds once exhausted.
    if (timeout) begin
      if (retry_q < MaxRetry) begin
        retry_d = retry_q + 2'd1;
        state_d = StPllRst;
      end else begin
        state_d = StFail;
      end
    end

    // Counter clears on every state change and saturates otherwise.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output decode from the next state so the registered outputs track state_q exactly.
  always_comb begin
    pll0_reset_d = 1'b0;
    gt_reset_d   = 1'b0;
    ready_d      = 1'b0;
    error_d      = 1'b0;
    unique case (state_d)
      StIdle, StPllRst, StFail: begin
        pll0_reset_d = 1'b1;
        gt_reset_d   = 1'b1;
      end
      StPllWait, StGtRst: gt_reset_d = 1'b1;
      default: ;
    endcase
    ready_d = (state_d == StReady);
    error_d = (state_d == StFail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll0_reset_q <= 1'b1;
      gt_reset_q   <= 1'b1;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      pll0_reset_q <= pll0_reset_d;
      gt_reset_q   <= gt_reset_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  assign pll0_reset  = pll0_reset_q;
  assign gt_tx_reset = gt_reset_q;
  assign gt_rx_reset = gt_reset_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_gtp_reset_sequencer.sv
// Directed bench for gtp_reset_sequencer with short pulse/timeout parameters.
// Inputs change and outputs are sampled on the falling clock edge. The wait
// helper counts falling edges until an output reaches a level.
module tb_gtp_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pll0_lock;
  logic       tx_reset_done;
  logic       rx_reset_done;
  logic       pll0_reset;
  logic       gt_tx_reset;
  logic       gt_rx_reset;
  logic       ready;
  logic       error;
  logic [1:0] retry_count;

  int checks = 0;
  int errors = 0;
  int n;

  // Output bit indices: 4 pll0_reset, 3 gt_tx_reset, 2 gt_rx_reset, 1 ready, 0 error.
  logic [4:0] outs;
  assign outs = {pll0_reset, gt_tx_reset, gt_rx_reset, ready, error};

  always #5 clk = ~clk;

  gtp_reset_sequencer #(
    .RESET_PULSE_CYCLES(4),
    .PLL_LOCK_TIMEOUT  (20),
    .DONE_TIMEOUT      (20),
    .MAX_RETRIES       (2),
    .CNT_W             (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pll0_lock    (pll0_lock),
    .tx_reset_done(tx_reset_done),
    .rx_reset_done(rx_reset_done),
    .pll0_reset   (pll0_reset),
    .gt_tx_reset  (gt_tx_reset),
    .gt_rx_reset  (gt_rx_reset),
    .ready        (ready),
    .error        (error),
    .retry_count  (retry_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Falling edges until outs[idx] == val; returns budget on expiry.
  task automatic wl(input int idx, input logic val, input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (outs[idx] !== val && cnt < budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; pll0_lock = 1'b0;
    tx_reset_done = 1'b0; rx_reset_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pll0", pll0_reset, 1);
    chk("rst_gt_tx", gt_tx_reset, 1);
    chk("rst_gt_rx", gt_rx_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_retry", retry_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: nominal bring-up.
    pulse_start();
    wl(4, 1'b0, 30, n);
    chk("nom_pll_pulse", n, 4);
    repeat (4) @(negedge clk);
    chk("nom_gt_held_in_pll_wait", gt_tx_reset, 1);
    pll0_lock = 1'b1;                     // 5 cycles after pll0_reset fell
    wl(3, 1'b0, 30, n);
    chk("nom_gt_fall", n, 7);             // 3 to act on lock + 4 of GT_RST
    chk("nom_gt_rx_fall", gt_rx_reset, 0);
    repeat (6) @(negedge clk);
    tx_reset_done = 1'b1; rx_reset_done = 1'b1;
    wl(1, 1'b1, 30, n);
    chk("nom_ready_lat", n, 3);
    chk("nom_retry", retry_count, 0);
    chk("nom_error", error, 0);
    chk("nom_pll0_low", pll0_reset, 0);

    // 4: lock drops for 10 cycles in READY.
    pll0_lock = 1'b0;
    wl(1, 1'b0, 30, n);
    chk("drop_ready_lat", n, 3);
    chk("drop_pll0_up", pll0_reset, 1);
    wl(4, 1'b0, 30, n);
    chk("drop_pll_pulse", n, 4);
    repeat (3) @(negedge clk);
    pll0_lock = 1'b1;
    // Dones stay high here, so GT_WAIT lasts one cycle: 3 + 4 + 1.
    wl(1, 1'b1, 60, n);
    chk("drop_reready", n, 8);
    chk("drop_retry", retry_count, 0);

    // 3: dones absent on the first attempt, present on the second.
    pll0_lock = 1'b0; tx_reset_done = 1'b0; rx_reset_done = 1'b0;
    do_reset();
    pulse_start();
    pll0_lock = 1'b1;
    wl(4, 1'b0, 30, n);
    chk("retry_pll_pulse1", n, 4);
    wl(4, 1'b1, 40, n);
    chk("retry_second_pulse", n, 25);     // 1 PLL_WAIT + 4 GT_RST + 20 GT_WAIT
    chk("retry_count1", retry_count, 1);
    tx_reset_done = 1'b1; rx_reset_done = 1'b1;
    wl(1, 1'b1, 30, n);
    chk("retry_ready", n, 10);
    chk("retry_count_held", retry_count, 1);
    chk("retry_error", error, 0);

    // 5: async reset in the middle of GT_WAIT.
    tx_reset_done = 1'b0; rx_reset_done = 1'b0;
    do_reset();
    pulse_start();
    repeat (11) @(negedge clk);
    chk("mid_in_gt_wait", gt_tx_reset, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pll0", pll0_reset, 1);
    chk("mid_rst_gt_tx", gt_tx_reset, 1);
    chk("mid_rst_gt_rx", gt_rx_reset, 1);
    chk("mid_rst_ready", ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx_reset_done = 1'b1; rx_reset_done = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_idle_pll0", pll0_reset, 1);
    chk("mid_idle_ready", ready, 0);

    // 2: lock never rises.
    pll0_lock = 1'b0; tx_reset_done = 1'b0; rx_reset_done = 1'b0;
    do_reset();
    pulse_start();
    wl(4, 1'b0, 30, n);
    chk("nolock_pulse1", n, 4);
    wl(4, 1'b1, 40, n);
    chk("nolock_wait1", n, 20);
    chk("nolock_retry1", retry_count, 1);
    wl(4, 1'b0, 30, n);
    chk("nolock_pulse2", n, 4);
    wl(4, 1'b1, 40, n);
    chk("nolock_wait2", n, 20);
    chk("nolock_retry2", retry_count, 2);
    wl(4, 1'b0, 30, n);
    chk("nolock_pulse3", n, 4);
    wl(0, 1'b1, 40, n);
    chk("nolock_wait3_fail", n, 20);
    chk("fail_pll0", pll0_reset, 1);
    chk("fail_gt_tx", gt_tx_reset, 1);
    chk("fail_ready", ready, 0);
    chk("fail_retry", retry_count, 2);
    repeat (3) @(negedge clk);
    chk("fail_sticky", error, 1);

    // 6: start in FAIL restarts; start during PLL_WAIT is ignored.
    pulse_start();
    chk("restart_error_clr", error, 0);
    chk("restart_pll0", pll0_reset, 1);
    chk("restart_retry_clr", retry_count, 0);
    wl(4, 1'b0, 30, n);
    chk("restart_pulse", n, 4);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wl(4, 1'b1, 40, n);
    chk("start_ignored_timeout", n, 17);  // timeout still 20 cycles after PLL_WAIT entry
    chk("start_ignored_retry", retry_count, 1);
    chk("start_ignored_error", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
